// File: rtl/coreapb3toahb_pkg.sv
// Shared types and AHB-Lite encodings for the APB3-to-AHB-Lite bridge state machine.
package coreapb3toahb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/coreapb3toahb_wdog.sv
// AHB stall watchdog: counts HREADY=0 cycles of one transfer and flags expiry.
// Only built when COREAPB3TOAHB_TIMEOUT_EN is defined.
`ifdef COREAPB3TOAHB_TIMEOUT_EN
module coreapb3toahb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic stall_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;

    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
    // Expiry is judged on the count this stall cycle would reach.
    assign expire_o = stall_i && (cnt_inc >= 17'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (stall_i && !expire_o) begin
            cnt_d = cnt_inc[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/coreapb3toahb_sm.sv
// APB3 completer to AHB-Lite manager bridge FSM: one APB access -> one single-beat NONSEQ.
// Optional stall timeout with transfer abandon under COREAPB3TOAHB_TIMEOUT_EN.
module coreapb3toahb_sm
    import coreapb3toahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("coreapb3toahb_sm: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
    logic                    hwrite_q, hwrite_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             prdata_q, prdata_d;
    logic                    err_q, err_d;
    logic                    setup_ok, enter_addr, timeout, hold_nonseq;

    assign enter_addr = (state_q == ST_IDLE) && setup_ok;

`ifdef COREAPB3TOAHB_TIMEOUT_EN
    logic abandon_q, abandon_d;
    logic ab_addr_q, ab_addr_d;
    logic stall;

    assign stall = ((state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_ERR)) && !HREADY;

    coreapb3toahb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk_i    (HCLK),
        .rst_i    (HRESET),
        .clear_i  (enter_addr),
        .stall_i  (stall),
        .expire_o (timeout)
    );

    // After a timeout the AHB transfer is tracked here, independently of the APB-facing FSM.
    always_comb begin
        abandon_d = abandon_q;
        ab_addr_d = ab_addr_q;
        if (timeout) begin
            abandon_d = 1'b1;
            ab_addr_d = (state_q == ST_ADDR);
        end else if (abandon_q && HREADY) begin
            if (ab_addr_q) begin
                ab_addr_d = 1'b0;
            end else begin
                abandon_d = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            abandon_q <= 1'b0;
            ab_addr_q <= 1'b0;
        end else begin
            abandon_q <= abandon_d;
            ab_addr_q <= ab_addr_d;
        end
    end

    assign setup_ok    = PSEL && !PENABLE && !abandon_q;
    assign hold_nonseq = abandon_q && ab_addr_q;
`else
    assign setup_ok    = PSEL && !PENABLE;
    assign timeout     = 1'b0;
    assign hold_nonseq = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_ok) begin
                    haddr_d  = PADDR;
                    hwrite_d = PWRITE;
                    wdata_d  = PWDATA;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    // HREADY=1 with ERROR and no preceding ERR cycle is still reported as an error.
                    if (HRESP == HRESP_ERROR) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (!hwrite_q) begin
                            prdata_d = HRDATA;
                        end
                    end
                    state_d = ST_DONE;
                end else if (HRESP == HRESP_ERROR) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = (state_q == ST_DONE);
    assign PSLVERR = (state_q == ST_DONE) && err_q;
    assign HADDR   = haddr_q;
    assign HTRANS  = ((state_q == ST_ADDR) || hold_nonseq) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE  = hwrite_q;
    assign HWDATA  = wdata_q;
    assign HSIZE   = HSIZE_WORD;
    assign HBURST  = HBURST_SINGLE;
    assign HPROT   = HPROT_DEFAULT;

endmodule

// File: tb/tb_coreapb3toahb_sm.sv
// Directed bench for coreapb3toahb_sm with a completion scoreboard; timeout steps need COREAPB3TOAHB_TIMEOUT_EN.
module tb_coreapb3toahb_sm;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    coreapb3toahb_sm #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] prdata;
        logic        slverr;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prdata_m = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_PRDATA"}, PRDATA, 32'h0);
        check({tag, "_PREADY"}, 32'(PREADY), 32'h0);
        check({tag, "_PSLVERR"}, 32'(PSLVERR), 32'h0);
        check({tag, "_HADDR"}, HADDR, 32'h0);
        check({tag, "_HTRANS"}, 32'(HTRANS), 32'h0);
        check({tag, "_HWRITE"}, 32'(HWRITE), 32'h0);
        check({tag, "_HWDATA"}, HWDATA, 32'h0);
    endtask

    // aw/dw: AHB wait cycles in address/data phase; er: two-cycle ERROR response after the data waits.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int aw, input int dw, input bit er);
        exp_t e;
        bit   done;
        int   d;
        e.prdata = (!wr && !er) ? rdata : prdata_m;
        e.slverr = er;
        e.lat    = 3 + aw + dw + (er ? 1 : 0);
        if (!wr && !er) prdata_m = rdata;
        sb.push_back(e);

        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge HCLK);
            PENABLE = 1'b1;
            if (PREADY) begin
                e = sb.pop_front();
                check("latency", 32'(cyc), 32'(e.lat));
                check("PSLVERR", 32'(PSLVERR), 32'(e.slverr));
                check("PRDATA", PRDATA, e.prdata);
                PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
                done = 1'b1;
            end else if (cyc <= aw + 1) begin
                check("addr_HTRANS", 32'(HTRANS), 32'h2);
                check("addr_HADDR", HADDR, addr);
                HREADY = (cyc == aw + 1);
            end else begin
                d = cyc - aw - 2;
                check("data_HTRANS", 32'(HTRANS), 32'h0);
                if (wr && d == 0) check("data_HWDATA", HWDATA, wdata);
                if (d < dw) begin
                    HREADY = 1'b0; HRESP = 1'b0;
                end else if (er && d == dw) begin
                    HREADY = 1'b0; HRESP = 1'b1;
                end else begin
                    HREADY = 1'b1; HRESP = er; HRDATA = rdata;
                end
            end
        end
        if (!done) begin
            check("PREADY_seen", 32'(done), 32'h1);
            sb.delete();
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        check_reset_values("rst");
        check("HSIZE", 32'(HSIZE), 32'h2);
        check("HBURST", 32'(HBURST), 32'h0);
        check("HPROT", 32'(HPROT), 32'h3);
        HRESET = 1'b0;

        apb_xfer(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        apb_xfer(1'b0, 32'h2000_0000, 32'h0, 32'h1234_5678, 0, 3, 1'b0);
        apb_xfer(1'b0, 32'h2000_0010, 32'h0, 32'hAAAA_5555, 0, 0, 1'b1);
        apb_xfer(1'b0, 32'h3000_0004, 32'h0, 32'hCAFE_F00D, 2, 0, 1'b0);
        apb_xfer(1'b1, 32'h3000_0008, 32'h0102_0304, 32'h0, 1, 1, 1'b0);
        apb_xfer(1'b1, 32'h3000_000C, 32'h0506_0708, 32'h0, 0, 2, 1'b1);

        // Reset while in the data phase of a write.
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4000_0008; PWDATA = 32'h55AA_33CC;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("mid_HWDATA", HWDATA, 32'h55AA_33CC);
        HRESET = 1'b1; HREADY = 1'b0;
        @(negedge HCLK);
        check_reset_values("midrst");
        HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        prdata_m = '0;

        apb_xfer(1'b1, 32'h4000_000C, 32'h9876_5432, 32'h0, 0, 0, 1'b0);
        apb_xfer(1'b0, 32'h5000_0000, 32'h0, 32'h0BAD_C0DE, 0, 0, 1'b0);

`ifdef COREAPB3TOAHB_TIMEOUT_EN
        // HREADY stuck low: timeout response in cycle 5, then the abandoned transfer drains before a new setup.
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h6000_0000;
        HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'hFFFF_0000;
        for (int c = 1; c <= 13; c++) begin
            @(negedge HCLK);
            check("to_PREADY", 32'(PREADY), 32'((c == 5) || (c == 13)));
            check("to_HTRANS", 32'(HTRANS), (c <= 8 || c == 11) ? 32'h2 : 32'h0);
            if (c <= 8) check("to_HADDR", HADDR, 32'h6000_0000);
            if (c == 5) check("to_PSLVERR", 32'(PSLVERR), 32'h1);
            if (c == 13) check("to_next_PSLVERR", 32'(PSLVERR), 32'h0);
            if (c == 5 || c == 13) check("to_PRDATA", PRDATA, prdata_m);
            if (c < 5) PENABLE = 1'b1;
            if (c == 5) begin
                PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h7000_0000; PWDATA = 32'h1111_2222;
            end
            HREADY = (c >= 8);
            if (c == 11) PENABLE = 1'b1;
            if (c == 13) begin
                PSEL = 1'b0; PENABLE = 1'b0;
            end
        end
`endif

        @(negedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
